// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register (hold / shift right / shift left / load)
// with bit counting that frames every WIDTH shifted bits into a word on a valid/ack port.
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ack,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] word_data_q, word_data_d;
  logic             word_valid_q, word_valid_d;
  logic             overrun_q, overrun_d;
  logic             shift_en;
  logic             word_done;

  assign mode_s    = mode_e'(mode);
  assign shift_en  = (mode_s == MODE_SHR) || (mode_s == MODE_SHL);
  assign word_done = shift_en && (bit_cnt_q == LAST_BIT);

  always_comb begin
    q_d = q_q;
    case (mode_s)
      MODE_SHR:  q_d = {serial_in, q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], serial_in};
      MODE_LOAD: q_d = parallel_in;
      default:   q_d = q_q;
    endcase
  end

  // A load abandons any partial word, so framing restarts from bit zero.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (mode_s == MODE_LOAD) begin
      bit_cnt_d = '0;
    end else if (shift_en) begin
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
    end
  end

  // Handshake: a word transfers on a clock edge where word_valid and word_ack are
  // both high; word_ack is ignored while word_valid is low, word_data is stable
  // while word_valid is high unless a newer word completes (then overrun is set
  // if the pending one was not acked on that same edge).
  always_comb begin
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;
    if (word_done) begin
      word_data_d  = q_d;
      word_valid_d = 1'b1;
      if (word_valid_q && !word_ack) begin
        overrun_d = 1'b1;
      end
    end else if (word_valid_q && word_ack) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q          <= '0;
      bit_cnt_q    <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      q_q          <= q_d;
      bit_cnt_q    <= bit_cnt_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign parallel_out = q_q;
  assign serial_out   = (mode_s == MODE_SHL) ? q_q[WIDTH-1] : q_q[0];
  assign word_data    = word_data_q;
  assign word_valid   = word_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4: linear steps with hand-computed
// expectations checked by immediate assertions.
module tb_univ_shift_reg;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [1:0]   mode;
  logic         serial_in;
  logic [W-1:0] parallel_in;
  logic [W-1:0] parallel_out;
  logic         serial_out;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         word_ack;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .serial_in    (serial_in),
    .parallel_in  (parallel_in),
    .parallel_out (parallel_out),
    .serial_out   (serial_out),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ack     (word_ack),
    .overrun      (overrun)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs, take one rising edge, settle 1 time unit
  task automatic step(input logic r, input logic [1:0] m, input logic sin,
                      input logic [W-1:0] pin, input logic ack);
    rst         = r;
    mode        = m;
    serial_in   = sin;
    parallel_in = pin;
    word_ack    = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [W-1:0] d, input logic v, input logic o);
    chk({tag, "_data"},  32'(word_data),  32'(d));
    chk({tag, "_valid"}, 32'(word_valid), 32'(v));
    chk({tag, "_ovr"},   32'(overrun),    32'(o));
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; serial_in = 1'b0; parallel_in = '0; word_ack = 1'b0;
    #2;

    // 1: reset, then four right shifts 1,0,1,1
    step(1, 2'b00, 0, 4'h0, 0);
    chk("rst_q", 32'(parallel_out), 32'h0);
    chk_word("rst", 4'h0, 0, 0);
    step(0, 2'b01, 1, 4'h0, 0); chk("t1_q1", 32'(parallel_out), 32'h8);
    step(0, 2'b01, 0, 4'h0, 0); chk("t1_q2", 32'(parallel_out), 32'h4);
    step(0, 2'b01, 1, 4'h0, 0); chk("t1_q3", 32'(parallel_out), 32'hA);
    chk("t1_novalid3", 32'(word_valid), 32'h0);
    step(0, 2'b01, 1, 4'h0, 0); chk("t1_q4", 32'(parallel_out), 32'hD);
    chk_word("t1_word", 4'hD, 1, 0);
    step(0, 2'b00, 0, 4'h0, 1);
    chk_word("t1_ack", 4'hD, 0, 0);
    chk("t1_hold_q", 32'(parallel_out), 32'hD);
    step(0, 2'b00, 0, 4'h0, 1);
    chk("t1_ack_idle", 32'(word_valid), 32'h0);

    // 2: clear register by load, then four left shifts 1,0,1,1
    step(0, 2'b11, 0, 4'h0, 0); chk("t2_load", 32'(parallel_out), 32'h0);
    step(0, 2'b10, 1, 4'h0, 0); chk("t2_q1", 32'(parallel_out), 32'h1);
    step(0, 2'b10, 0, 4'h0, 0); chk("t2_q2", 32'(parallel_out), 32'h2);
    step(0, 2'b10, 1, 4'h0, 0); chk("t2_q3", 32'(parallel_out), 32'h5);
    step(0, 2'b10, 1, 4'h0, 0); chk("t2_q4", 32'(parallel_out), 32'hB);
    chk_word("t2_word", 4'hB, 1, 0);
    step(0, 2'b00, 0, 4'h0, 1);
    chk("t2_ack", 32'(word_valid), 32'h0);

    // 3: load 1001, serial_out before the shift, one right shift of 0
    step(0, 2'b11, 0, 4'h9, 0); chk("t3_load", 32'(parallel_out), 32'h9);
    mode = 2'b01; serial_in = 1'b0; #1;
    chk("t3_sout", 32'(serial_out), 32'h1);
    step(0, 2'b01, 0, 4'h0, 0); chk("t3_q", 32'(parallel_out), 32'h4);
    chk("t3_novalid", 32'(word_valid), 32'h0);

    // serial_out selection with asymmetric contents 1000
    step(0, 2'b11, 0, 4'h8, 0);
    mode = 2'b10; #1; chk("so_left",  32'(serial_out), 32'h1);
    mode = 2'b01; #1; chk("so_right", 32'(serial_out), 32'h0);
    mode = 2'b00; #1; chk("so_hold",  32'(serial_out), 32'h0);

    // 4: eight right shifts 1,1,1,1,0,0,0,0 with no ack -> overrun
    step(0, 2'b11, 0, 4'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'b01, 1, 4'h0, 0);
    chk_word("t4_w1", 4'hF, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 2'b01, 0, 4'h0, 0);
    chk_word("t4_mid", 4'hF, 1, 0);
    step(0, 2'b01, 0, 4'h0, 0);
    chk_word("t4_w2", 4'h0, 1, 1);
    step(0, 2'b00, 0, 4'h0, 1);
    chk_word("t4_ack", 4'h0, 0, 1);
    step(0, 2'b00, 0, 4'h0, 0);
    chk("t4_sticky", 32'(overrun), 32'h1);

    // 5: reset, pending word 0101, two shifts, load, four shifts with ack on the last
    step(1, 2'b01, 1, 4'h0, 0);
    chk_word("t5_rst", 4'h0, 0, 0);
    step(0, 2'b01, 1, 4'h0, 0);
    step(0, 2'b01, 0, 4'h0, 0);
    step(0, 2'b01, 1, 4'h0, 0);
    step(0, 2'b01, 0, 4'h0, 0);
    chk_word("t5_prior", 4'h5, 1, 0);
    step(0, 2'b01, 1, 4'h0, 0);
    step(0, 2'b01, 1, 4'h0, 0); chk("t5_q2", 32'(parallel_out), 32'hD);
    step(0, 2'b11, 0, 4'h0, 0);
    step(0, 2'b01, 0, 4'h0, 0);
    step(0, 2'b01, 1, 4'h0, 0);
    step(0, 2'b01, 1, 4'h0, 0);
    chk_word("t5_pre4", 4'h5, 1, 0);
    step(0, 2'b01, 0, 4'h0, 1);
    chk("t5_q4", 32'(parallel_out), 32'h6);
    chk_word("t5_ackdone", 4'h6, 1, 0);

    // 6: three shifts with a word pending, then reset mid-word
    step(0, 2'b01, 1, 4'h0, 0);
    step(0, 2'b01, 1, 4'h0, 0);
    step(0, 2'b01, 1, 4'h0, 0); chk("t6_q3", 32'(parallel_out), 32'hE);
    step(1, 2'b01, 1, 4'h0, 0);
    chk("t6_rst_q", 32'(parallel_out), 32'h0);
    chk_word("t6_rst", 4'h0, 0, 0);
    step(0, 2'b01, 1, 4'h0, 0);
    step(0, 2'b01, 0, 4'h0, 0);
    step(0, 2'b01, 0, 4'h0, 0);
    chk("t6_novalid3", 32'(word_valid), 32'h0);
    step(0, 2'b01, 1, 4'h0, 0);
    chk_word("t6_word", 4'h9, 1, 0);

    // mixed directions count toward one word: right 0, right 1, left 1, left 0
    step(0, 2'b00, 0, 4'h0, 1);
    step(0, 2'b01, 0, 4'h0, 0); chk("mx_q1", 32'(parallel_out), 32'h4);
    step(0, 2'b01, 1, 4'h0, 0); chk("mx_q2", 32'(parallel_out), 32'hA);
    step(0, 2'b10, 1, 4'h0, 0); chk("mx_q3", 32'(parallel_out), 32'h5);
    chk("mx_novalid", 32'(word_valid), 32'h0);
    step(0, 2'b10, 0, 4'h0, 0);
    chk_word("mx_word", 4'hA, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
